dds_freq_meter: RTL and testbench

- Measurement counterpart of the team's DDS phase-accumulator generator. The generator turns a 32-bit tuning word K into a square wave; this block takes a square wave and recovers K.
- It counts rising edges of an asynchronous input over a gate of 2^GATE_LOG2 clk cycles.
- Result is K = edge_count << (32 - GATE_LOG2), directly reusable as the generator's frequency word.
- Used for closed-loop self-test of the DDS and for measuring external reference clocks.

---
 rtl/dds_pkg.sv | 21 ++
 rtl/dds_edge_sync.sv | 49 ++++
 rtl/dds_freq_meter.sv | 124 ++++++++++++
 tb/tb_dds_freq_meter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dds_pkg
// Desc     : Constants and meter state encoding shared by the DDS generator
//            and the DDS frequency meter.
// Revision : 1.0 - initial release
// ============================================================================
package dds_pkg;

    localparam int DDS_K_W = 32;
    localparam int DDS_P_W = 11;

    typedef logic [1:0] meter_state_t;

    localparam meter_state_t c_st_idle    = 2'd0;
    localparam meter_state_t c_st_arm     = 2'd1;
    localparam meter_state_t c_st_measure = 2'd2;
    localparam meter_state_t c_st_done    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dds_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : dds_edge_sync
// Desc     : Synchronizes an asynchronous square wave and emits a one-cycle
//            registered pulse on each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module dds_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic edge_p
);

    localparam int c_sup_n = SYNC_STAGES + 1;
    localparam int c_sup_w = $clog2(c_sup_n + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;
    logic [c_sup_w-1:0]     r_sup_cnt;
    logic                   w_sup_done;

    // A high input at reset exit would look like a rising edge, so edges
    // are masked until the chain and previous-sample flop have filled.
    assign w_sup_done = (r_sup_cnt == c_sup_w'(c_sup_n));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_prev    <= 1'b0;
            r_edge    <= 1'b0;
            r_sup_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev & w_sup_done;
            if (!w_sup_done) begin
                r_sup_cnt <= r_sup_cnt + 1'b1;
            end
        end
    end

    assign edge_p = r_edge;

endmodule
`default_nettype wire

// File: rtl/dds_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : dds_freq_meter
// Desc     : Counts rising edges of sig_in over a 2^GATE_LOG2 cycle gate and
//            reports the result as a DDS tuning word.
// Revision : 1.0 - initial release
// ============================================================================
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int GATE_LOG2   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig_in,
    input  logic                start,
    input  logic                cont,
    output logic                busy,
    output logic                k_valid,
    output logic [DDS_K_W-1:0]  k_out,
    output logic                no_sig
);

    localparam logic [GATE_LOG2:0] c_gate_last = {1'b0, {GATE_LOG2{1'b1}}};

    meter_state_t           r_state;
    meter_state_t           w_state_nxt;
    logic [GATE_LOG2:0]     r_gate_cnt;
    logic [GATE_LOG2-1:0]   r_edge_cnt;
    logic [GATE_LOG2-1:0]   w_edge_total;
    logic [DDS_K_W-1:0]     r_k_out;
    logic                   r_no_sig;
    logic                   w_edge_p;
    logic                   w_gate_end;
    logic                   w_timeout;
    logic                   w_meas_end;

    dds_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .edge_p (w_edge_p)
    );

    assign w_gate_end   = (r_gate_cnt == c_gate_last);
    assign w_edge_total = r_edge_cnt + GATE_LOG2'(w_edge_p);

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_meas_end  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_arm;
                end
            end
            c_st_arm: begin
                if (w_edge_p) begin
                    w_state_nxt = c_st_measure;
                end else if (w_gate_end) begin
                    w_state_nxt = c_st_done;
                    w_timeout   = 1'b1;
                end
            end
            c_st_measure: begin
                if (w_gate_end) begin
                    w_state_nxt = c_st_done;
                    w_meas_end  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = (cont | start) ? c_st_arm : c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_k_out    <= '0;
            r_no_sig   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_arm: begin
                    // The arming edge opens the window and is not itself counted.
                    if (w_edge_p) begin
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + 1'b1;
                    end
                end
                c_st_measure: begin
                    r_gate_cnt <= r_gate_cnt + 1'b1;
                    r_edge_cnt <= w_edge_total;
                end
                default: begin
                    r_gate_cnt <= '0;
                end
            endcase
            if (w_timeout) begin
                r_k_out  <= '0;
                r_no_sig <= 1'b1;
            end else if (w_meas_end) begin
                r_k_out  <= {w_edge_total, {(DDS_K_W-GATE_LOG2){1'b0}}};
                r_no_sig <= 1'b0;
            end
        end
    end

    assign busy    = (r_state == c_st_arm) | (r_state == c_st_measure);
    assign k_valid = (r_state == c_st_done);
    assign k_out   = r_k_out;
    assign no_sig  = r_no_sig;

endmodule
`default_nettype wire

// File: tb/tb_dds_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_freq_meter
// Desc     : Directed self-checking bench for dds_freq_meter at GATE_LOG2=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_freq_meter;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        sig_in  = 1'b0;
    logic        start   = 1'b0;
    logic        cont    = 1'b0;
    logic        busy;
    logic        k_valid;
    logic [31:0] k_out;
    logic        no_sig;

    int total = 0;
    int bad   = 0;

    // Stimulus source: 0 = static level, 1 = periodic, 2 = DDS generator model
    int          gen_mode   = 0;
    int          gen_period = 4;
    int          gen_phase  = 0;
    logic        gen_level  = 1'b0;
    logic [31:0] dds_k      = 32'd0;
    logic [31:0] dds_acc    = 32'd0;

    always #5 clk = ~clk;

    dds_freq_meter #(
        .GATE_LOG2   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .start   (start),
        .cont    (cont),
        .busy    (busy),
        .k_valid (k_valid),
        .k_out   (k_out),
        .no_sig  (no_sig)
    );

    always @(negedge clk) begin
        case (gen_mode)
            0: sig_in = gen_level;
            1: begin
                gen_phase = (gen_phase + 1 >= gen_period) ? 0 : gen_phase + 1;
                sig_in    = (gen_phase < gen_period / 2);
            end
            default: begin
                dds_acc = dds_acc + dds_k;
                sig_in  = dds_acc[31];
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_kv(input int max_cyc, output int n, output logic busy_before,
                           output logic found);
        n           = 0;
        found       = 1'b0;
        busy_before = busy;
        while (!found && n < max_cyc) begin
            busy_before = busy;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (k_valid) found = 1'b1;
        end
    endtask

    task automatic count_kv(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (k_valid) c++;
        end
    endtask

    task automatic measure(input string tag, input logic [31:0] exp_k, input logic exp_nosig);
        int   n;
        logic bb;
        logic f;
        pulse_start();
        wait_kv(400, n, bb, f);
        check({tag, "_found"}, {31'd0, f}, 32'd1);
        check({tag, "_k"}, k_out, exp_k);
        check({tag, "_nosig"}, {31'd0, no_sig}, {31'd0, exp_nosig});
    endtask

    initial begin
        int   n;
        int   c;
        logic bb;
        logic f;

        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, busy},    32'd0);
        check("rst_kvalid", {31'd0, k_valid}, 32'd0);
        check("rst_kout",   k_out,            32'd0);
        check("rst_nosig",  {31'd0, no_sig},  32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Period 4: 64 edges in 256 cycles, busy falls with k_valid
        gen_mode   = 1;
        gen_period = 4;
        gen_phase  = 0;
        repeat (8) @(negedge clk);
        pulse_start();
        wait_kv(400, n, bb, f);
        check("p4_found",       {31'd0, f},       32'd1);
        check("p4_k",           k_out,            32'h4000_0000);
        check("p4_nosig",       {31'd0, no_sig},  32'd0);
        check("p4_busy_done",   {31'd0, busy},    32'd0);
        check("p4_busy_before", {31'd0, bb},      32'd1);
        @(negedge clk);
        check("p4_kvalid_pulse", {31'd0, k_valid}, 32'd0);

        gen_period = 3;
        measure("p3", 32'h5500_0000, 1'b0);
        gen_period = 2;
        measure("p2", 32'h8000_0000, 1'b0);

        // No signal: timeout 257 cycles after the start cycle
        gen_mode  = 0;
        gen_level = 1'b0;
        repeat (6) @(negedge clk);
        pulse_start();
        wait_kv(400, n, bb, f);
        check("to_found", {31'd0, f},      32'd1);
        check("to_lat",   32'(n + 1),      32'd257);
        check("to_k",     k_out,           32'd0);
        check("to_nosig", {31'd0, no_sig}, 32'd1);

        gen_mode   = 1;
        gen_period = 4;
        measure("recover", 32'h4000_0000, 1'b0);

        // sig_in high across reset release must not produce an edge
        gen_mode  = 0;
        gen_level = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst2_kout", k_out, 32'd0);
        rst   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_kv(400, n, bb, f);
        check("hi_found", {31'd0, f},      32'd1);
        check("hi_lat",   32'(n + 1),      32'd257);
        check("hi_k",     k_out,           32'd0);
        check("hi_nosig", {31'd0, no_sig}, 32'd1);

        // Continuous mode with a period change inside the second window
        gen_mode   = 1;
        gen_period = 8;
        gen_phase  = 0;
        cont       = 1'b1;
        repeat (4) @(negedge clk);
        pulse_start();
        wait_kv(400, n, bb, f);
        check("c1_found", {31'd0, f}, 32'd1);
        check("c1_k",     k_out,      32'h2000_0000);
        repeat (130) @(negedge clk);
        gen_period = 16;
        gen_phase  = 0;
        wait_kv(400, n, bb, f);
        check("c2_found", {31'd0, f}, 32'd1);
        check("c2_mixed", {31'd0, (k_out > 32'h1000_0000) && (k_out < 32'h2000_0000)}, 32'd1);
        wait_kv(400, n, bb, f);
        check("c3_found",    {31'd0, f}, 32'd1);
        check("c3_k",        k_out,      32'h1000_0000);
        check("c3_interval", {31'd0, (n >= 258) && (n <= 273)}, 32'd1);
        repeat (50) @(negedge clk);
        cont = 1'b0;
        wait_kv(400, n, bb, f);
        check("c4_found", {31'd0, f}, 32'd1);
        check("c4_k",     k_out,      32'h1000_0000);
        count_kv(300, c);
        check("c4_stop_kv",   32'(c),        32'd0);
        check("c4_stop_busy", {31'd0, busy}, 32'd0);

        // Reset mid-measurement aborts without a result
        gen_period = 4;
        gen_phase  = 0;
        pulse_start();
        repeat (60) @(negedge clk);
        pulse_start();
        check("ab_busy", {31'd0, busy}, 32'd1);
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ab_busy0",   {31'd0, busy},    32'd0);
        check("ab_kvalid0", {31'd0, k_valid}, 32'd0);
        check("ab_kout0",   k_out,            32'd0);
        check("ab_nosig0",  {31'd0, no_sig},  32'd0);
        rst = 1'b0;
        count_kv(600, c);
        check("ab_no_kv", 32'(c), 32'd0);

        // Starts while busy are ignored: one result per accepted start
        pulse_start();
        repeat (40) @(negedge clk);
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        count_kv(500, c);
        check("ign_kv_count", 32'(c),        32'd1);
        check("ign_k",        k_out,         32'h4000_0000);
        check("ign_idle",     {31'd0, busy}, 32'd0);

        // Loopback from the DDS generator model with K = 0x1000_0000
        dds_k    = 32'h1000_0000;
        dds_acc  = 32'd0;
        gen_mode = 2;
        repeat (20) @(negedge clk);
        measure("loop", 32'h1000_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
